// File: rtl/uart_arb_pkg.sv
// Shared types and default sizing for the UART transmit arbiter.
package uart_arb_pkg;

  localparam int unsigned DEF_NUM_REQ      = 4;
  localparam int unsigned DEF_DATA_W       = 8;
  localparam int unsigned DEF_BUSY_TIMEOUT = 16;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } arb_state_t;

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin selector: first set request above ptr, wrapping.
module rr_pick #(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);

  logic [IW-1:0] cand;

  // Scan offsets 1..N from the pointer so the last winner has lowest priority.
  always_comb begin
    gnt  = '0;
    idx  = '0;
    any  = 1'b0;
    cand = '0;
    for (int k = 1; k <= int'(N); k++) begin
      cand = IW'((32'(ptr) + 32'(k)) % 32'(N));
      if (!any && req[cand]) begin
        any       = 1'b1;
        idx       = cand;
        gnt[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ byte sources.
// Optional busy-rise timeout enabled by defining UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ      = DEF_NUM_REQ,
  parameter int unsigned DATA_W       = DEF_DATA_W,
  parameter int unsigned BUSY_TIMEOUT = DEF_BUSY_TIMEOUT
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic [DATA_W-1:0]           uart_din,
  output logic                        uart_wr_en,
  input  logic                        uart_tx_busy,
  output logic [$clog2(NUM_REQ)-1:0]  grant_id,
  output logic                        active,
  output logic                        timeout_err
);

  localparam int unsigned IW = $clog2(NUM_REQ);

  // Reject unsupported configurations at elaboration.
  if (NUM_REQ < 2 || NUM_REQ > 8 || DATA_W < 1 || BUSY_TIMEOUT < 1) begin : g_bad_param
    $error("uart_tx_arbiter: unsupported parameter set");
  end

  arb_state_t         state;
  logic [IW-1:0]      ptr;
  logic [NUM_REQ-1:0] pick_gnt;
  logic [IW-1:0]      pick_idx;
  logic               pick_any;
  logic               grant_ok;

  rr_pick #(.N(NUM_REQ), .IW(IW)) u_pick (
    .req (req_valid),
    .ptr (ptr),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .any (pick_any)
  );

  // A grant is only offered from IDLE while the UART is free.
  assign grant_ok  = !rst && (state == IDLE) && !uart_tx_busy && pick_any;
  assign req_ready = grant_ok ? pick_gnt : '0;
  assign active    = (state != IDLE);

`ifdef UART_ARB_TIMEOUT_EN
  localparam int unsigned TW = $clog2(BUSY_TIMEOUT + 1);
  logic [TW-1:0] busy_cnt;
`else
  assign timeout_err = 1'b0;
`endif

  // Byte sequencer: latch winner, strobe wr_en, track tx_busy rise and fall.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      uart_din   <= '0;
      uart_wr_en <= 1'b0;
      grant_id   <= '0;
      ptr        <= IW'(NUM_REQ - 1);
`ifdef UART_ARB_TIMEOUT_EN
      busy_cnt    <= '0;
      timeout_err <= 1'b0;
`endif
    end else begin
      uart_wr_en <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
      timeout_err <= 1'b0;
`endif
      unique case (state)
        IDLE: begin
          if (grant_ok) begin
            uart_din   <= req_data[32'(pick_idx)*DATA_W +: DATA_W];
            grant_id   <= pick_idx;
            ptr        <= pick_idx;
            uart_wr_en <= 1'b1;
            state      <= ISSUE;
          end
        end
        ISSUE: begin
          state <= WAIT_BUSY;
`ifdef UART_ARB_TIMEOUT_EN
          busy_cnt <= '0;
`endif
        end
        WAIT_BUSY: begin
          if (uart_tx_busy) begin
            state <= WAIT_DONE;
          end
`ifdef UART_ARB_TIMEOUT_EN
          else if (busy_cnt == TW'(BUSY_TIMEOUT - 1)) begin
            timeout_err <= 1'b1;
            state       <= IDLE;
          end else begin
            busy_cnt <= busy_cnt + TW'(1);
          end
`endif
        end
        WAIT_DONE: begin
          if (!uart_tx_busy) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
